// File: rtl/conv2d_frame_sched.sv
// conv2d_frame_sched: walks a 3x3 stride-1 window over an IMG_W x IMG_H map, feeds the conv engine, writes results
// Ports: clk/rst (async active-high); go starts a frame from IDLE; busy high outside IDLE; frame_done one-cycle
// pulse after the last write; rd_en/rd_addr/rd_data read the pixel RAM (data one cycle after strobe);
// win_flat carries the nine window bytes to the engine; eng_start/eng_done/eng_out handshake with the engine;
// wr_en/wr_addr/wr_data write results in raster order.
// Optional macro SAT8_EN: clamp wr_data to 255 for 8-bit next-layer storage.
module conv2d_frame_sched #(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    output logic              busy,
    output logic              frame_done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic [71:0]       win_flat,
    output logic              eng_start,
    input  logic              eng_done,
    input  logic [15:0]       eng_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data
);
    typedef enum logic [2:0] {IDLE, FETCH, CAPT, START, RUN, WRITE, DONE} state_t;
    state_t state, state_n;
    logic [3:0] k, k_n;
    logic [ADDR_W-1:0] r, c, r_n, c_n, rd_addr_n, wr_addr_n;
    logic [15:0] res_n;
    logic last;
    assign last = (r == ADDR_W'(IMG_H-3)) && (c == ADDR_W'(IMG_W-3));
    // outputs are registered from next-state values so rd_en rises the cycle after go is sampled
    assign rd_addr_n = (r_n + ADDR_W'(k_n / 4'd3)) * ADDR_W'(IMG_W) + c_n + ADDR_W'(k_n % 4'd3);
    assign wr_addr_n = r_n * ADDR_W'(IMG_W-2) + c_n;
`ifdef SAT8_EN
    assign res_n = (eng_out > 16'd255) ? 16'd255 : eng_out;
`else
    assign res_n = eng_out;
`endif
    always_comb begin
        state_n = state;
        k_n = k;
        r_n = r;
        c_n = c;
        case (state)
            IDLE: if (go) begin
                state_n = FETCH;
                k_n = '0;
                r_n = '0;
                c_n = '0;
            end
            FETCH: begin
                k_n = (k == 4'd8) ? 4'd0 : k + 4'd1;
                state_n = (k == 4'd8) ? CAPT : FETCH;
            end
            CAPT: state_n = START;
            START: state_n = RUN;
            RUN: state_n = eng_done ? WRITE : RUN;
            WRITE: begin
                c_n = (c == ADDR_W'(IMG_W-3)) ? '0 : c + 1'b1;
                r_n = (c == ADDR_W'(IMG_W-3)) ? r + 1'b1 : r;
                state_n = last ? DONE : FETCH;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            k <= '0;
            r <= '0;
            c <= '0;
            busy <= 1'b0;
            frame_done <= 1'b0;
            rd_en <= 1'b0;
            rd_addr <= '0;
            win_flat <= '0;
            eng_start <= 1'b0;
            wr_en <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state <= state_n;
            k <= k_n;
            r <= r_n;
            c <= c_n;
            busy <= state_n != IDLE;
            frame_done <= state_n == DONE;
            rd_en <= state_n == FETCH;
            eng_start <= state_n == START;
            wr_en <= state_n == WRITE;
            if (state_n == FETCH)
                rd_addr <= rd_addr_n;
            // bytes arrive in k order; nine shifts leave element 0 in the low byte
            if ((state == FETCH && k != 4'd0) || state == CAPT)
                win_flat <= {rd_data, win_flat[71:8]};
            if (state == RUN && eng_done) begin
                wr_addr <= wr_addr_n;
                wr_data <= res_n;
            end
        end
    end
endmodule

// File: tb/tb_conv2d_frame_sched.sv
// tb_conv2d_frame_sched: randomized self-checking bench with a RAM, an engine model and a raster reference model
module tb_conv2d_frame_sched;
    localparam int W = 8, H = 8, AW = 8, NW = (W-2)*(H-2);
    logic clk = 1'b0, rst = 1'b1, go = 1'b0, go3 = 1'b0;
    logic busy, frame_done, rd_en, eng_start, eng_done, wr_en;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [7:0] rd_data;
    logic [71:0] win_flat;
    logic [15:0] eng_out, wr_data;
    logic busy3, fd3, rd_en3, start3, wr_en3;
    logic done3 = 1'b1;
    logic [AW-1:0] rd_addr3, wr_addr3;
    logic [7:0] rd_data3;
    logic [71:0] win3;
    logic [15:0] out3 = 16'h1234, wr_data3;
    logic [7:0] img [64];
    logic [7:0] img3 [16];
    logic [7:0] ker [9];
    int eng_lat = 3, cnt = 0, s, cyc = 0, go_cyc, fd_base;
    int total = 0, bad = 0;
    int wq_addr[$], wq_data[$], wq_cyc[$], rq[$];
    logic [71:0] wq_win[$];
    int fd_cnt = 0, fd_cyc = 0, bfall = 0, ovl = 0;
    int rq3[$], w3_addr[$], w3_data[$];
    logic [71:0] win3q[$];
    int fd3_cnt = 0, fd3_cyc = 0;
    logic busy_q = 1'b0;

    conv2d_frame_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .go(go), .busy(busy), .frame_done(frame_done),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .win_flat(win_flat),
        .eng_start(eng_start), .eng_done(eng_done), .eng_out(eng_out),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data));

    conv2d_frame_sched #(.IMG_W(3), .IMG_H(3), .ADDR_W(AW)) dut3 (
        .clk(clk), .rst(rst), .go(go3), .busy(busy3), .frame_done(fd3),
        .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3), .win_flat(win3),
        .eng_start(start3), .eng_done(done3), .eng_out(out3),
        .wr_en(wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        if (rd_en) rd_data <= img[rd_addr[5:0]];
        if (rd_en3) rd_data3 <= img3[rd_addr3[3:0]];
    end

    // engine: result from the presented window, done raised in the eng_lat-th cycle after start
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            eng_done <= 1'b0;
            eng_out <= '0;
            cnt <= 0;
        end else if (eng_start) begin
            s = 0;
            for (int i = 0; i < 9; i++) s += int'(win_flat[8*i +: 8]) * int'(ker[i]);
            eng_out <= s[15:0];
            eng_done <= (eng_lat == 1);
            cnt <= eng_lat - 1;
        end else if (cnt > 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) eng_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(int'(wr_addr));
            wq_data.push_back(int'(wr_data));
            wq_cyc.push_back(cyc);
        end
        if (rd_en) rq.push_back(int'(rd_addr));
        if (eng_start) wq_win.push_back(win_flat);
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
        if (busy_q && !busy) bfall++;
        busy_q = busy;
        if (wr_en && (rd_en || eng_start)) ovl++;
        if (rd_en3) rq3.push_back(int'(rd_addr3));
        if (start3) win3q.push_back(win3);
        if (wr_en3) begin
            w3_addr.push_back(int'(wr_addr3));
            w3_data.push_back(int'(wr_data3));
        end
        if (fd3) begin
            fd3_cnt++;
            fd3_cyc = cyc;
        end
    end

    function automatic logic [15:0] exp_res(int r, int c);
        int acc = 0;
        logic [15:0] v;
        for (int i = 0; i < 9; i++) acc += int'(img[(r+i/3)*W + c + i%3]) * int'(ker[i]);
        v = acc[15:0];
`ifdef SAT8_EN
        return (v > 16'd255) ? 16'd255 : v;
`else
        return v;
`endif
    endfunction

    function automatic logic [71:0] exp_win(int r, int c);
        logic [71:0] w;
        for (int i = 0; i < 9; i++) w[8*i +: 8] = img[(r+i/3)*W + c + i%3];
        return w;
    endfunction

    task automatic clear_q();
        wq_addr.delete(); wq_data.delete(); wq_cyc.delete(); rq.delete(); wq_win.delete();
        fd_base = fd_cnt;
    endtask

    task automatic start_frame();
        clear_q();
        @(negedge clk) go = 1'b1;
        @(posedge clk) #1 go_cyc = cyc;
    endtask

    task automatic run_frame();
        start_frame();
        @(negedge clk) go = 1'b0;
        for (int n = 0; n < 20000 && fd_cnt == fd_base; n++) begin
            @(negedge clk);
            #1;
        end
        total++;
        if (fd_cnt == fd_base) begin
            bad++;
            $display("FAIL frame_timeout: frame_done count %0d, required %0d", fd_cnt, fd_base + 1);
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic check_frame(string tag);
        int e = 0;
        total++;
        if (wq_addr.size() != NW) begin
            bad++;
            $display("FAIL %s write_count: got %0d want %0d", tag, wq_addr.size(), NW);
        end
        for (int i = 0; i < NW && i < wq_addr.size(); i++) begin
            total += 3;
            if (wq_addr[i] != i) begin
                bad++;
                $display("FAIL %s wr_addr[%0d]: got %0d want %0d", tag, i, wq_addr[i], i);
            end
            if (wq_data[i] != int'(exp_res(i/(W-2), i%(W-2)))) begin
                bad++;
                $display("FAIL %s wr_data[%0d]: got %0d want %0d", tag, i, wq_data[i], exp_res(i/(W-2), i%(W-2)));
            end
            if (i >= wq_win.size() || wq_win[i] !== exp_win(i/(W-2), i%(W-2))) begin
                bad++;
                $display("FAIL %s win_flat[%0d]: got %h want %h", tag, i, (i < wq_win.size()) ? wq_win[i] : 72'h0, exp_win(i/(W-2), i%(W-2)));
            end
        end
        for (int i = 1; i < wq_cyc.size(); i++) if (wq_cyc[i] - wq_cyc[i-1] != 12 + eng_lat) e++;
        total++;
        if (e != 0) begin
            bad++;
            $display("FAIL %s write_spacing: %0d gaps differ from %0d", tag, e, 12 + eng_lat);
        end
        e = (rq.size() == NW*9) ? 0 : 1;
        for (int i = 0; i < rq.size() && i < NW*9; i++) begin
            int wi = i / 9, kk = i % 9;
            if (rq[i] != (wi/(W-2) + kk/3)*W + wi%(W-2) + kk%3) e++;
        end
        total++;
        if (e != 0) begin
            bad++;
            $display("FAIL %s read_sequence: %0d errors over %0d reads, want %0d reads", tag, e, rq.size(), NW*9);
        end
        total += 3;
        if (fd_cnt - fd_base != 1) begin
            bad++;
            $display("FAIL %s frame_done_pulses: got %0d want 1", tag, fd_cnt - fd_base);
        end
        if (fd_cyc - go_cyc != NW*(12 + eng_lat)) begin
            bad++;
            $display("FAIL %s frame_latency: got %0d want %0d", tag, fd_cyc - go_cyc, NW*(12 + eng_lat));
        end
        if (ovl != 0) begin
            bad++;
            $display("FAIL %s wr_overlap: got %0d want 0", tag, ovl);
        end
    endtask

    task automatic check_zero(string tag);
        total++;
        if ({busy, frame_done, rd_en, rd_addr, win_flat, eng_start, wr_en, wr_addr, wr_data} !== '0) begin
            bad++;
            $display("FAIL %s outputs: got busy=%b fd=%b rd_en=%b rd_addr=%0d win=%h start=%b wr_en=%b wr_addr=%0d wr_data=%0d want all 0",
                     tag, busy, frame_done, rd_en, rd_addr, win_flat, eng_start, wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_reset();
        #2;
        check_zero("reset");
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_zero("idle_after_reset");
    endtask

    task automatic test_ones();
        foreach (img[i]) img[i] = 8'd1;
        foreach (ker[i]) ker[i] = 8'd1;
        eng_lat = 3;
        run_frame();
        check_frame("ones");
        total += 2;
        if (wq_data.size() == 0 || wq_data[0] != 9) begin
            bad++;
            $display("FAIL ones_value: got %0d want 9", (wq_data.size() > 0) ? wq_data[0] : -1);
        end
        if (fd_cyc - go_cyc + 1 != 541) begin
            bad++;
            $display("FAIL ones_done_cycle: got %0d want 541", fd_cyc - go_cyc + 1);
        end
    endtask

    task automatic test_ramp();
        int fw[9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
        foreach (img[i]) img[i] = 8'(i);
        foreach (ker[i]) ker[i] = 8'($urandom_range(0, 15));
        eng_lat = $urandom_range(1, 4);
        run_frame();
        check_frame("ramp");
        for (int i = 0; i < 9; i++) begin
            total += 2;
            if (rq.size() < 9 || rq[i] != fw[i]) begin
                bad++;
                $display("FAIL ramp_first_read[%0d]: got %0d want %0d", i, (rq.size() > i) ? rq[i] : -1, fw[i]);
            end
            if (wq_win.size() == 0 || int'(wq_win[0][8*i +: 8]) != fw[i]) begin
                bad++;
                $display("FAIL ramp_first_win[%0d]: got %0d want %0d", i, (wq_win.size() > 0) ? int'(wq_win[0][8*i +: 8]) : -1, fw[i]);
            end
        end
        total++;
        if (rq.size() != NW*9 || rq[(NW-1)*9] != 45) begin
            bad++;
            $display("FAIL ramp_last_window_start: got %0d want 45", (rq.size() == NW*9) ? rq[(NW-1)*9] : -1);
        end
    endtask

    task automatic test_sat();
        int want;
`ifdef SAT8_EN
        want = 255;
`else
        want = 900;
`endif
        foreach (img[i]) img[i] = 8'd100;
        foreach (ker[i]) ker[i] = 8'd1;
        eng_lat = 2;
        run_frame();
        check_frame("sat");
        total++;
        if (wq_data.size() == 0 || wq_data[0] != want) begin
            bad++;
            $display("FAIL sat_value: got %0d want %0d", (wq_data.size() > 0) ? wq_data[0] : -1, want);
        end
    endtask

    task automatic test_go_held();
        int b0 = bfall;
        foreach (img[i]) img[i] = 8'($urandom);
        foreach (ker[i]) ker[i] = 8'($urandom);
        eng_lat = 1;
        start_frame();
        for (int n = 0; n < 5000 && wq_addr.size() < NW; n++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        @(posedge clk);
        #1 go = 1'b0;
        repeat (40) @(negedge clk);
        #1;
        check_frame("go_held");
        total += 2;
        if (bfall - b0 != 1) begin
            bad++;
            $display("FAIL go_held_busy_falls: got %0d want 1", bfall - b0);
        end
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL go_held_idle: busy got %b want 0", busy);
        end
    endtask

    task automatic test_rst_mid();
        int f0;
        foreach (img[i]) img[i] = 8'd1;
        foreach (ker[i]) ker[i] = 8'd1;
        eng_lat = 3;
        start_frame();
        @(negedge clk) go = 1'b0;
        for (int n = 0; n < 2000 && wq_win.size() < 6; n++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        #1;
        total++;
        if (wq_win.size() != 6 || busy !== 1'b1 || eng_start !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_setup: starts got %0d want 6, busy=%b start=%b", wq_win.size(), busy, eng_start);
        end
        rst = 1'b1;
        #1;
        check_zero("rst_mid");
        f0 = fd_cnt;
        @(negedge clk) rst = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check_zero("rst_mid_idle");
        total++;
        if (fd_cnt != f0) begin
            bad++;
            $display("FAIL rst_mid_no_done: frame_done pulses got %0d want 0", fd_cnt - f0);
        end
        run_frame();
        check_frame("rst_restart");
    endtask

    task automatic test_random();
        for (int t = 0; t < 3; t++) begin
            foreach (img[i]) img[i] = 8'($urandom);
            foreach (ker[i]) ker[i] = 8'($urandom);
            eng_lat = $urandom_range(1, 5);
            run_frame();
            check_frame("random");
        end
    endtask

    task automatic test_small();
        int f0 = fd3_cnt, g3, want;
        logic [71:0] w;
`ifdef SAT8_EN
        want = 255;
`else
        want = 16'h1234;
`endif
        foreach (img3[i]) img3[i] = 8'($urandom);
        for (int i = 0; i < 9; i++) w[8*i +: 8] = img3[i];
        @(negedge clk) go3 = 1'b1;
        @(posedge clk) #1 g3 = cyc;
        @(negedge clk) go3 = 1'b0;
        for (int n = 0; n < 200 && fd3_cnt == f0; n++) begin
            @(negedge clk);
            #1;
        end
        total += 5;
        if (fd3_cnt - f0 != 1 || fd3_cyc - g3 != 13) begin
            bad++;
            $display("FAIL small_done: pulses %0d latency %0d want 1 and 13", fd3_cnt - f0, fd3_cyc - g3);
        end
        if (rq3.size() != 9) begin
            bad++;
            $display("FAIL small_read_count: got %0d want 9", rq3.size());
        end
        for (int i = 0; i < 9 && i < rq3.size(); i++) if (rq3[i] != i) begin
            bad++;
            $display("FAIL small_read[%0d]: got %0d want %0d", i, rq3[i], i);
        end
        if (win3q.size() != 1 || win3q[0] !== w) begin
            bad++;
            $display("FAIL small_win: got %h want %h", (win3q.size() > 0) ? win3q[0] : 72'h0, w);
        end
        if (w3_addr.size() != 1 || w3_addr[0] != 0 || w3_data[0] != want) begin
            bad++;
            $display("FAIL small_write: count %0d addr %0d data %0d want 1, 0, %0d", w3_addr.size(),
                     (w3_addr.size() > 0) ? w3_addr[0] : -1, (w3_data.size() > 0) ? w3_data[0] : -1, want);
        end
    endtask

    initial begin
        test_reset();
        test_ones();
        test_ramp();
        test_sat();
        test_go_held();
        test_rst_mid();
        test_random();
        test_small();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/conv2d_frame_sched.md
# conv2d_frame_sched

Frame-level scheduler for the 3×3 convolution engine (start/done handshake, 9 pixel + 9 kernel byte inputs, 16-bit result). It walks a stride-1, no-padding window over an IMG_W×IMG_H 8-bit feature map held in a synchronous RAM. For each window it fetches the nine pixels, presents them to the engine, pulses start and waits for done. It then writes the result to an output buffer, raster order. Kernel bytes are wired directly to the engine and are outside this block.

## Interface
- IMG_W, 8, input map width in pixels (≥3)
- IMG_H, 8, input map height in pixels (≥3)
- ADDR_W, 8, read/write address width; must hold IMG_W*IMG_H-1
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- go  in  1  frame start request; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after last output written
- rd_en  out  1  RAM read strobe
- rd_addr  out  ADDR_W  RAM read address
- rd_data  in  8  RAM read data, valid the cycle after rd_en
- win_flat  out  72  window; element i = dr*3+dc at bits [8i+7:8i], maps to engine in0..in8
- eng_start  out  1  engine start pulse
- eng_done  in  1  engine completion
- eng_out  in  16  engine result, valid while eng_done high
- wr_en  out  1  output buffer write strobe
- wr_addr  out  ADDR_W  output index r*(IMG_W-2)+c
- wr_data  out  16  output value

## Operation
- All outputs registered; reset value 0 for every output; state → IDLE, row/col counters → 0.
- States: IDLE, FETCH, CAPT, START, RUN, WRITE, DONE.
- IDLE: go=1 → FETCH with r=c=0, k=0. go=0 → stay.
- FETCH (9 cycles, k=0..8): rd_en=1, rd_addr=(r+k/3)*IMG_W + c + k%3. For k≥1, win[k-1] ← rd_data. After k=8 → CAPT.
- CAPT: rd_en=0, win[8] ← rd_data → START.
- START: eng_start=1 for exactly this cycle → RUN.
- RUN: eng_start=0; wait for eng_done=1, latch result → WRITE. eng_done is ignored in START. The engine clears done on the edge that samples start.
- WRITE: wr_en=1 for one cycle, wr_addr=r*(IMG_W-2)+c, wr_data=result. Advance c; on wrap c=IMG_W-3 → c=0, r+1. After r=IMG_H-3, c=IMG_W-3 → DONE, else → FETCH.
- DONE: frame_done=1 for one cycle → IDLE.
- win_flat is held stable from CAPT through WRITE.
- go outside IDLE, including the DONE cycle, is ignored; not queued.
- rst mid-frame: immediate async clear of all state and outputs; partial frame abandoned, no frame_done.

## Timing
- Per output: 9 (FETCH) + 1 (CAPT) + 1 (START) + L (RUN) + 1 (WRITE) = 12+L cycles. L = number of RUN cycles up to and including the first with eng_done=1 (L≥1).
- Frame: (IMG_W-2)(IMG_H-2)(12+L) + 1 cycles from the go-sampling edge to frame_done falling.
- First rd_en is asserted the cycle after go is sampled.
- wr_en never overlaps rd_en or eng_start.

## Configuration
- SAT8_EN defined: wr_data = (result > 255) ? 16'd255 : result, i.e. unsigned clamp for 8-bit next-layer storage.
- SAT8_EN undefined: wr_data = result unmodified.

## Test plan
- Default params, all-ones image, engine model with all-ones kernel and done 3 cycles after start (L=3) → 36 writes, wr_data=9, wr_addr 0..35 in order. Writes 15 cycles apart. Single frame_done pulse at cycle 541.
- Ramp image, pixel=address → first window reads 0,1,2,8,9,10,16,17,18. win_flat bytes match those values. Last window reads start at 45.
- All pixels 100, ones kernel → engine result 900. wr_data=255 with SAT8_EN, 900 without.
- go held high through the frame and pulsed in the DONE cycle → exactly 36 writes, busy falls once, no second frame.
- rst asserted during RUN of output 5 → all outputs 0 in the same cycle, state IDLE. Next go restarts with rd_addr 0 and wr_addr 0.
- IMG_W=IMG_H=3 → one window (reads 0..8), one write at wr_addr 0, then frame_done.
